// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter: round-robin arbiter sharing one sigmoid unit among N requesters over ARG/RES/ERR/FBK channels
module sigmoid_arbiter #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_en,
  input  logic [N-1:0]    req_arg_stb,
  input  logic [16*N-1:0] req_arg_dat,
  output logic [N-1:0]    req_arg_rdy,
  output logic [N-1:0]    req_res_stb,
  input  logic [N-1:0]    req_res_rdy,
  output logic [7:0]      req_res_dat,
  input  logic [N-1:0]    req_err_stb,
  input  logic [16*N-1:0] req_err_dat,
  output logic [N-1:0]    req_err_rdy,
  output logic [N-1:0]    req_fbk_stb,
  input  logic [N-1:0]    req_fbk_rdy,
  output logic [15:0]     req_fbk_dat,
  output logic            sig_en,
  output logic            sig_arg_stb,
  output logic [15:0]     sig_arg_dat,
  input  logic            sig_arg_rdy,
  input  logic            sig_res_stb,
  input  logic [7:0]      sig_res_dat,
  output logic            sig_res_rdy,
  output logic            sig_err_stb,
  output logic [15:0]     sig_err_dat,
  input  logic            sig_err_rdy,
  input  logic            sig_fbk_stb,
  input  logic [15:0]     sig_fbk_dat,
  output logic            sig_fbk_rdy,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic [CW-1:0]   cnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [2:0] {IDLE, ARG, RES, ERR, FBK} state_t;
  state_t        state;
  logic          en_r;
  logic          done;
  logic [PW-1:0] ptr;
  logic [PW-1:0] own;
  logic [PW-1:0] nxt;
  logic [15:0]   arg_mux;
  logic [15:0]   err_mux;
  always_comb begin
    own     = '0;
    arg_mux = '0;
    err_mux = '0;
    for (int i = 0; i < N; i++)
      if (gnt[i]) begin
        own     = PW'(i);
        arg_mux = req_arg_dat[16*i +: 16];
        err_mux = req_err_dat[16*i +: 16];
      end
  end
  // scan downward so the requester closest after ptr overwrites the others
  always_comb begin
    nxt = ptr;
    for (int k = N; k >= 1; k--)
      if (req_arg_stb[PW'((int'(ptr) + k) % N)]) nxt = PW'((int'(ptr) + k) % N);
  end
  assign sig_arg_stb = (state == ARG) && |(req_arg_stb & gnt);
  assign sig_arg_dat = arg_mux;
  assign req_arg_rdy = (state == ARG && sig_arg_rdy) ? gnt : '0;
  assign req_res_stb = (state == RES && sig_res_stb) ? gnt : '0;
  assign sig_res_rdy = (state == RES) && |(req_res_rdy & gnt);
  assign req_res_dat = sig_res_dat;
  assign sig_err_stb = (state == ERR) && |(req_err_stb & gnt);
  assign sig_err_dat = err_mux;
  assign req_err_rdy = (state == ERR && sig_err_rdy) ? gnt : '0;
  assign req_fbk_stb = (state == FBK && sig_fbk_stb) ? gnt : '0;
  assign sig_fbk_rdy = (state == FBK) && |(req_fbk_rdy & gnt);
  assign req_fbk_dat = sig_fbk_dat;
  assign busy        = state != IDLE;
  assign sig_en      = busy && en_r;
  assign done        = (state == RES && sig_res_stb && sig_res_rdy && !en_r) ||
                       (state == FBK && sig_fbk_stb && sig_fbk_rdy);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      gnt   <= '0;
      en_r  <= 1'b0;
      ptr   <= PW'(N - 1);
      cnt   <= '0;
    end else if (done) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= own;
      cnt   <= cnt + 1'b1;
    end else begin
      case (state)
        IDLE: if (|req_arg_stb) begin
          state <= ARG;
          gnt   <= N'(1) << nxt;
          en_r  <= req_en[nxt];
        end
        ARG: if (sig_arg_stb && sig_arg_rdy) state <= RES;
        RES: if (sig_res_stb && sig_res_rdy) state <= ERR;
        ERR: if (sig_err_stb && sig_err_rdy) state <= FBK;
        default: ;
      endcase
    end
  end
endmodule
